// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if -- request/result bundle for the multiply/divide unit.
//   start      : begin a new operation (sampled on rising clk)
//   op[1:0]    : 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a, b       : operand A / dividend / mthi-mtlo data, operand B / divisor
//   mthi, mtlo : write a into HI / LO while the unit is not calculating
//   busy, done : calculation in progress / one-cycle completion pulse
//   hi, lo     : HI (product upper word / remainder), LO (product lower / quotient)
// master drives requests, slave (the unit) drives status and results.
interface mul_div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, mthi, mtlo,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, a, b, mthi, mtlo,
                  output busy, done, hi, lo);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit -- iterative 32x32 multiply / 32/32 divide with HI/LO registers.
// One iteration per clock, 32 iterations per operation (shift-add multiply,
// restoring divide). Results land in hi/lo on the edge ending the last
// iteration, together with a one-cycle done pulse.
// Ports:
//   clk  : rising-edge clock
//   clrn : asynchronous active-low reset
//   bus  : mul_div_unit_if.slave (start/op/a/b/mthi/mtlo in, busy/done/hi/lo out)
// Configuration: define MDU_SIGNED_EN to enable signed MULT/DIV (op[0]=1);
// otherwise op[0] is ignored and all operations are unsigned.
module mul_div_unit (
  input logic             clk,
  input logic             clrn,
  mul_div_unit_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        op_div;
  logic [31:0] opnd;       // multiplicand or divisor magnitude
  logic [64:0] work;       // multiply: {partial product, multiplier}; divide: {rem, quotient}
  logic        busy_r;
  logic        done_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  logic        sgn;
  logic [31:0] mag_a;
  logic [31:0] mag_b;

`ifdef MDU_SIGNED_EN
  logic neg_res;
  logic neg_rem;
  assign sgn   = bus.op[0];
  assign mag_a = (sgn && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
  assign mag_b = (sgn && bus.b[31]) ? (32'd0 - bus.b) : bus.b;
`else
  logic unused_op0;
  assign unused_op0 = bus.op[0];
  assign sgn   = 1'b0;
  assign mag_a = bus.a;
  assign mag_b = bus.b;
`endif

  logic        accept;
  assign accept = bus.start && (state != CALC);

  // One iteration step plus final-result formatting.
  logic [32:0] sum;
  logic [32:0] rem_s;
  logic        ge;
  logic [31:0] diff;
  logic [64:0] work_next;
  logic [63:0] mul_res;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  always_comb begin
    sum       = work[64:32] + {1'b0, opnd};
    rem_s     = {work[63:32], work[31]};
    ge        = rem_s >= {1'b0, opnd};
    diff      = rem_s[31:0] - opnd;  // true difference fits 32 bits whenever ge
    work_next = work;
    if (!op_div) begin
      if (work[0]) work_next = {1'b0, sum, work[31:1]};
      else         work_next = {1'b0, work[64:1]};
    end else begin
      if (ge) work_next = {1'b0, diff,        work[30:0], 1'b1};
      else    work_next = {1'b0, rem_s[31:0], work[30:0], 1'b0};
    end
    mul_res = work_next[63:0];
    div_q   = work_next[31:0];
    div_r   = work_next[63:32];
`ifdef MDU_SIGNED_EN
    if (neg_res) begin
      mul_res = 64'd0 - mul_res;
      div_q   = 32'd0 - div_q;
    end
    if (neg_rem) div_r = 32'd0 - div_r;
`endif
    res_hi = op_div ? div_r : mul_res[63:32];
    res_lo = op_div ? div_q : mul_res[31:0];
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state  <= IDLE;
      cnt    <= '0;
      op_div <= 1'b0;
      opnd   <= '0;
      work   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
`ifdef MDU_SIGNED_EN
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      unique case (state)
        CALC: begin
          work <= work_next;
          cnt  <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            hi_r   <= res_hi;
            lo_r   <= res_lo;
          end
        end
        default: begin
          if (accept) begin
            // start wins over a coincident mthi/mtlo, whose write is dropped
            state  <= CALC;
            busy_r <= 1'b1;
            cnt    <= '0;
            op_div <= bus.op[1];
            opnd   <= bus.op[1] ? mag_b : mag_a;
            work   <= {33'd0, bus.op[1] ? mag_a : mag_b};
`ifdef MDU_SIGNED_EN
            neg_res <= sgn && (bus.a[31] ^ bus.b[31]);
            neg_rem <= sgn && bus.a[31];
`endif
          end else begin
            state <= IDLE;
            if (bus.mthi) hi_r <= bus.a;
            if (bus.mtlo) lo_r <= bus.a;
          end
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
  logic clk;
  logic clrn;
  int   errors;
  int   checks;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mul_div_unit_if bus();

  mul_div_unit dut (.clk(clk), .clrn(clrn), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Reference: {hi,lo} from arithmetic on the operation's definition.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    logic        s;
    longint      sa;
    longint      sb;
    longint      q;
    longint      rm;
    s = 1'b0;
`ifdef MDU_SIGNED_EN
    s = op[0];
`endif
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!op[1]) begin
      if (s) r = 64'(sa * sb);
      else   r = 64'(a) * 64'(b);
    end else if (b == 32'd0) begin
      r = {a, 32'hFFFFFFFF};
    end else if (s) begin
      q  = sa / sb;
      rm = sa % sb;
      r  = {rm[31:0], q[31:0]};
    end else begin
      r = {a % b, a / b};
    end
    return r;
  endfunction

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Called at the negedge of cycle k0 after acceptance; returns at the done cycle.
  task automatic run_to_done(input int k0, input logic [31:0] hold_hi, input logic [31:0] hold_lo,
                             output int busy_cycles, output int done_at, output bit held);
    busy_cycles = 0; done_at = 0; held = 1'b1;
    for (int k = k0; k <= k0 + 40; k++) begin
      if (bus.busy) busy_cycles++;
      if (bus.done) begin
        done_at = k;
        break;
      end
      if (bus.hi !== hold_hi || bus.lo !== hold_lo) held = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 0", bus.hi); end
    checks++; if (bus.lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 0", bus.lo); end
    clrn = 1'b1;
    exp_hi = '0; exp_lo = '0;
  endtask

  task automatic test_move();
    @(negedge clk);
    bus.a = 32'h1234; bus.mthi = 1'b1; bus.mtlo = 1'b1;
    @(negedge clk);
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    checks++; if (bus.hi !== 32'h1234) begin errors++; $display("FAIL move_hi: got %h expected 1234", bus.hi); end
    checks++; if (bus.lo !== 32'h1234) begin errors++; $display("FAIL move_lo: got %h expected 1234", bus.lo); end
    bus.a = 32'hCAFE0000; bus.mthi = 1'b1;
    @(negedge clk);
    bus.mthi = 1'b0;
    checks++; if (bus.hi !== 32'hCAFE0000) begin errors++; $display("FAIL mthi_only_hi: got %h expected cafe0000", bus.hi); end
    checks++; if (bus.lo !== 32'h1234) begin errors++; $display("FAIL mthi_only_lo: got %h expected 1234", bus.lo); end
    exp_hi = 32'hCAFE0000; exp_lo = 32'h1234;
  endtask

  task automatic test_multu();
    int bc; int da; bit held;
    launch(2'b00, 32'hFFFFFFFF, 32'd2);
    run_to_done(1, exp_hi, exp_lo, bc, da, held);
    checks++; if (bc !== 32) begin errors++; $display("FAIL multu_busy_cycles: got %0d expected 32", bc); end
    checks++; if (da !== 33) begin errors++; $display("FAIL multu_done_cycle: got %0d expected 33", da); end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL multu_hold: got %b expected 1", held); end
    checks++; if (bus.hi !== 32'd1) begin errors++; $display("FAIL multu_hi: got %h expected 1", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_lo: got %h expected fffffffe", bus.lo); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL multu_done_width: got %b expected 0", bus.done); end
    exp_hi = 32'd1; exp_lo = 32'hFFFFFFFE;
  endtask

  task automatic test_divu();
    int bc; int da; bit held;
    launch(2'b10, 32'd100, 32'd7);
    run_to_done(1, exp_hi, exp_lo, bc, da, held);
    checks++; if (da !== 33) begin errors++; $display("FAIL divu_done_cycle: got %0d expected 33", da); end
    checks++; if (bus.lo !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h expected e", bus.lo); end
    checks++; if (bus.hi !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h expected 2", bus.hi); end
    launch(2'b10, 32'd5, 32'd0);
    run_to_done(1, 32'd2, 32'd14, bc, da, held);
    checks++; if (da !== 33) begin errors++; $display("FAIL div0_done_cycle: got %0d expected 33", da); end
    checks++; if (bus.lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL div0_lo: got %h expected ffffffff", bus.lo); end
    checks++; if (bus.hi !== 32'd5) begin errors++; $display("FAIL div0_hi: got %h expected 5", bus.hi); end
    exp_hi = 32'd5; exp_lo = 32'hFFFFFFFF;
  endtask

  task automatic test_random();
    int bc; int da; bit held;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] e;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 50);
`ifdef MDU_SIGNED_EN
      if (op == 2'b11 && b == 32'd0) b = 32'd1;
`endif
      e = model(op, a, b);
      launch(op, a, b);
      run_to_done(1, exp_hi, exp_lo, bc, da, held);
      checks++; if (da !== 33) begin errors++; $display("FAIL rand_done_cycle[%0d]: got %0d expected 33", i, da); end
      checks++; if (held !== 1'b1) begin errors++; $display("FAIL rand_hold[%0d]: got %b expected 1", i, held); end
      checks++; if (bus.hi !== e[63:32]) begin errors++; $display("FAIL rand_hi[%0d] op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, bus.hi, e[63:32]); end
      checks++; if (bus.lo !== e[31:0]) begin errors++; $display("FAIL rand_lo[%0d] op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, bus.lo, e[31:0]); end
      exp_hi = e[63:32]; exp_lo = e[31:0];
    end
  endtask

`ifdef MDU_SIGNED_EN
  task automatic test_signed();
    int bc; int da; bit held;
    launch(2'b01, 32'hFFFFFFFD, 32'd5);
    run_to_done(1, exp_hi, exp_lo, bc, da, held);
    checks++; if ({bus.hi, bus.lo} !== 64'hFFFFFFFF_FFFFFFF1) begin errors++; $display("FAIL mult_signed: got %h%h expected fffffffffffffff1", bus.hi, bus.lo); end
    launch(2'b11, 32'hFFFFFFF9, 32'd2);
    run_to_done(1, bus.hi, bus.lo, bc, da, held);
    checks++; if (bus.lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_signed_lo: got %h expected fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_signed_hi: got %h expected ffffffff", bus.hi); end
    launch(2'b11, 32'h80000000, 32'hFFFFFFFF);
    run_to_done(1, 32'hFFFFFFFF, 32'hFFFFFFFD, bc, da, held);
    checks++; if (da !== 33) begin errors++; $display("FAIL div_ovf_done_cycle: got %0d expected 33", da); end
    checks++; if (bus.lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo: got %h expected 80000000", bus.lo); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL div_ovf_hi: got %h expected 0", bus.hi); end
    exp_hi = 32'd0; exp_lo = 32'h80000000;
  endtask
`endif

  task automatic test_back_to_back();
    int bc; int da; bit held;
    launch(2'b10, 32'd1000, 32'd9);
    repeat (9) @(negedge clk);
    // cycle 10 of CALC: these must all be ignored
    bus.start = 1'b1; bus.mthi = 1'b1; bus.op = 2'b00; bus.a = 32'h0000FFFF; bus.b = 32'h0000FFFF;
    @(negedge clk);
    bus.start = 1'b0; bus.mthi = 1'b0;
    run_to_done(11, exp_hi, exp_lo, bc, da, held);
    checks++; if (da !== 33) begin errors++; $display("FAIL collide_done_cycle: got %0d expected 33", da); end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL collide_hold: got %b expected 1", held); end
    checks++; if (bus.hi !== 32'd1) begin errors++; $display("FAIL collide_hi: got %h expected 1", bus.hi); end
    checks++; if (bus.lo !== 32'd111) begin errors++; $display("FAIL collide_lo: got %h expected 6f", bus.lo); end
    // start sampled in the DONE cycle
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd7; bus.b = 32'd6;
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", bus.busy); end
    run_to_done(1, 32'd1, 32'd111, bc, da, held);
    checks++; if (da !== 33) begin errors++; $display("FAIL b2b_done_cycle: got %0d expected 33", da); end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL b2b_hold: got %b expected 1", held); end
    checks++; if ({bus.hi, bus.lo} !== 64'd42) begin errors++; $display("FAIL b2b_result: got %h%h expected 42 decimal", bus.hi, bus.lo); end
    exp_hi = 32'd0; exp_lo = 32'd42;
  endtask

  task automatic test_reset_mid();
    bit seen_done;
    bit seen_busy;
    launch(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (19) @(negedge clk);
    clrn = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL midreset_hi: got %h expected 0", bus.hi); end
    checks++; if (bus.lo !== 32'd0) begin errors++; $display("FAIL midreset_lo: got %h expected 0", bus.lo); end
    @(negedge clk);
    clrn = 1'b1;
    seen_done = 1'b0; seen_busy = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
      if (bus.busy) seen_busy = 1'b1;
    end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL midreset_no_done: got %b expected 0", seen_done); end
    checks++; if (seen_busy !== 1'b0) begin errors++; $display("FAIL midreset_no_busy: got %b expected 0", seen_busy); end
    checks++; if ({bus.hi, bus.lo} !== 64'd0) begin errors++; $display("FAIL midreset_after: got %h%h expected 0", bus.hi, bus.lo); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_move();
    test_multu();
    test_divu();
`ifdef MDU_SIGNED_EN
    test_signed();
`endif
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: clrn  input  1  asynchronous active-low reset.
REQ-003 SHALL have port: start  input  1  request a new operation; sampled on the rising edge of clk.
REQ-004 SHALL have port: op  input  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-005 SHALL have port: a  input  32  operand A / dividend / mthi-mtlo data, driven from register-file port qa.
REQ-006 SHALL have port: b  input  32  operand B / divisor, driven from register-file port qb.
REQ-007 SHALL have port: mthi  input  1  write a into HI.
REQ-008 SHALL have port: mtlo  input  1  write a into LO.
REQ-009 SHALL have port: busy  output  1  operation in progress.
REQ-010 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: hi  output  32  HI register (product upper word / remainder).
REQ-012 SHALL have port: lo  output  32  LO register (product lower word / quotient).

Function
REQ-013 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-014 SHALL accept start only in IDLE or DONE; on acceptance it SHALL latch a, b and op, clear a 5-bit iteration counter, and enter CALC.
REQ-015 SHALL ignore start, mthi and mtlo while in CALC.
REQ-016 SHALL perform exactly one iteration per cycle in CALC (shift-add multiply, restoring divide) and SHALL leave CALC after 32 iterations.
REQ-017 SHALL, on the edge ending the 32nd iteration, write final results to hi/lo, enter DONE, and assert done for exactly one cycle.
REQ-018 SHALL drive busy=1 only in CALC, so a start accepted at edge N gives busy high over cycles N+1..N+32 and done high at cycle N+33.
REQ-019 SHALL leave DONE for IDLE after one cycle, or go directly to CALC if start is sampled in DONE.
REQ-020 SHALL produce a 64-bit product for multiply, with {hi,lo}=A*B.
REQ-021 SHALL produce lo=quotient and hi=remainder for divide.
REQ-022 SHALL, for a divisor of 0, complete with the normal latency and give lo=32'hFFFFFFFF and hi=dividend.
REQ-023 SHALL keep hi/lo unchanged from start acceptance until the DONE write, so hi/lo read during CALC return the previous values.
REQ-024 SHALL, in IDLE/DONE, write hi<=a on mthi and lo<=a on mtlo; both may be asserted in the same cycle.
REQ-025 SHALL give start priority when start and mthi/mtlo coincide, and SHALL discard the mthi/mtlo write.

Reset
REQ-026 SHALL, while clrn=0 and regardless of clk, force state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, and clear the latched operands.
REQ-027 SHALL, if reset occurs mid-CALC, abandon the operation, never assert done for it, and leave hi=lo=0.

Configuration
REQ-028 SHALL support signed operation when macro MDU_SIGNED_EN is defined. With it, MULT/DIV SHALL operate on operand magnitudes and apply sign fix-up in the DONE write with no added latency: product sign = sign(A) xor sign(B); quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
REQ-029 SHALL, with MDU_SIGNED_EN defined, return lo=32'h80000000 and hi=0 for signed 32'h80000000 / 32'hFFFFFFFF.
REQ-030 SHALL, without MDU_SIGNED_EN, ignore op[0] and perform all operations unsigned.

Verification
REQ-031 SHALL check MULTU: a=32'hFFFFFFFF, b=2, start -> busy for 32 cycles, done at cycle 33, hi=1, lo=32'hFFFFFFFE.
REQ-032 SHALL check DIVU: a=100, b=7 -> lo=14, hi=2; also DIVU with b=0, a=5 -> lo=32'hFFFFFFFF, hi=5.
REQ-033 SHALL check, with MDU_SIGNED_EN: MULT -3*5 -> {hi,lo}=64'hFFFFFFFF_FFFFFFF1; DIV -7/2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
REQ-034 SHALL check start and mthi asserted together in cycle 10 of CALC -> both ignored; then a new start asserted in the DONE cycle is accepted and done appears again 33 cycles later.
REQ-035 SHALL check clrn pulsed low at iteration 20 -> busy=0, hi=lo=0 immediately, no done pulse follows.
REQ-036 SHALL check mthi=mtlo=1, a=32'h1234 in IDLE -> hi=lo=32'h1234 on the next edge.
